pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Sequences the IF/ID, ID/EX and EX/MEM pipeline registers of the 5-stage MIPS core.
//  Generates PC/stage enables and bubble/flush strobes for three cases:
//   - load-use hazards;
//   - jump/jr redirects resolved in MEM;
//   - a multi-cycle iterative multiplier in EX, whose start and completion this block controls.
//  Sits beside the hazard/forwarding logic; drives the stage-register enable/flush pins.
// PARAMETERS
//  MUL_CYCLES  32  multiplier iterations per mul instruction (must be >= 2)
//  CNT_W        6  width of iteration counter (>= clog2(MUL_CYCLES)+1)
//  PERF_W      32  width of stall/flush performance counters
// PORTS
//  clk           in   1       clock, rising edge
//  rst           in   1       reset: asynchronous, active-high
//  id_rs         in   5       rs field of instruction in ID
//  id_rt         in   5       rt field of instruction in ID
//  id_uses_rt    in   1       ID instruction reads rt (R-type, sw, beq)
//  idex_rf_wa    in   5       dest reg of instruction in EX (ID_EX stage)
//  idex_we_reg   in   1       EX instruction writes the register file
//  idex_dm2reg   in   1       EX instruction is a load
//  idex_muxmul   in   1       EX instruction is a multiply
//  exmem_jump    in   1       MEM instruction is a taken j/jal
//  exmem_jrSrc   in   1       MEM instruction is a taken jr
//  pc_en         out  1       PC update enable
//  ifid_en       out  1       IF/ID capture enable
//  idex_en       out  1       ID/EX capture enable
//  ifid_flush    out  1       IF/ID loads a nop
//  idex_flush    out  1       ID/EX loads a bubble (control fields zero)
//  exmem_flush   out  1       EX/MEM loads a bubble (we_reg, we_dm, jump, jrSrc = 0)
//  mul_start     out  1       one-cycle pulse: multiplier latches operands
//  mul_abort     out  1       one-cycle pulse: multiplier discards its operation
//  mul_busy      out  1       registered; high during MUL_RUN
//  stall_cnt     out  PERF_W  registered count of cycles with pc_en = 0
//  flush_cnt     out  PERF_W  registered count of redirects (exmem_jump | exmem_jrSrc)
// BEHAVIOUR
//  Reset:
//   - state = IDLE, counter = 0, mul_busy/stall_cnt/flush_cnt = 0.
//   - While rst is high: all enables = 1, all flushes/pulses = 0.
//  Redirect (redir = exmem_jump | exmem_jrSrc), highest priority, combinational:
//   - ifid_flush = idex_flush = exmem_flush = 1; enables = 1.
//   - If state != IDLE: mul_abort = 1, and next state = IDLE.
//   - If state == IDLE: mul_start is suppressed.
//  FSM states IDLE, MUL_RUN, MUL_WB:
//   - IDLE, idex_muxmul & !redir:
//       - mul_start = 1; cnt <= MUL_CYCLES-2; -> MUL_RUN.
//       - Same cycle: pc_en = ifid_en = idex_en = 0; exmem_flush = 1.
//   - MUL_RUN:
//       - Stall as above; mul_busy = 1.
//       - cnt == 0 -> MUL_WB, else cnt--.
//   - MUL_WB:
//       - All enables = 1; exmem_flush = 0 (EX/MEM captures multi/muxmul result).
//       - -> IDLE. No re-trigger: ID/EX advances on this edge.
//   - Total latency: mul in EX for exactly MUL_CYCLES+1 cycles; MUL_CYCLES stall cycles.
//  Load-use (IDLE only, no redir, no mul):
//   - Condition: idex_dm2reg & idex_we_reg & idex_rf_wa != 0 &
//     (idex_rf_wa == id_rs | (id_uses_rt & idex_rf_wa == id_rt)).
//   - Response: pc_en = ifid_en = 0, idex_flush = 1, for one cycle.
//  Priority: redirect > multiply stall > load-use.
//   - Load-use is never raised outside IDLE.
//  Counters: saturate at all-ones.
//   - stall_cnt++ whenever pc_en == 0.
//   - flush_cnt++ per redir cycle.
//  Reset mid-operation: returns to IDLE immediately; no mul_abort pulse is emitted.
// STRUCTURE
//  Package pipe_ctrl_pkg holds:
//   - state encoding (IDLE = 2'd0, MUL_RUN = 2'd1, MUL_WB = 2'd2);
//   - REG_ZERO = 5'd0;
//   - the bubble-control constant.
//  One sub-module, mul_seq_fsm: multiplier FSM plus iteration counter (start/abort/busy/wb).
//  Top level holds: load-use compare, priority mux, perf counters.
// TESTING
//  1. lw $t0 in EX, ID add reads $t0 as rs -> one cycle pc_en = 0, idex_flush = 1; then pc_en = 1.
//  2. lw to $0 in EX, ID reads $0 -> no stall; stall_cnt unchanged.
//  3. mul in EX, MUL_CYCLES = 4:
//     - mul_start pulses in cycle 0;
//     - pc_en = 0 and exmem_flush = 1 in cycles 0-3;
//     - MUL_WB in cycle 4 (enables = 1); stall_cnt = 4.
//  4. exmem_jrSrc = 1 during MUL_RUN cnt = 1 -> mul_abort = 1 and all three flushes = 1;
//     state IDLE next cycle; flush_cnt = 1.
//  5. Redirect and load-use hazard in same cycle -> flushes only, pc_en = 1, no load-use stall.
//  6. rst asserted mid MUL_RUN -> mul_busy = 0 asynchronously; counters = 0;
//     after release, a mul in EX restarts with mul_start.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings and stage-control constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MUL_RUN = 2'd1,
    ST_MUL_WB  = 2'd2
  } mul_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
  } stage_ctrl_t;

  localparam stage_ctrl_t CTRL_RUN = '{pc_en: 1'b1, ifid_en: 1'b1, idex_en: 1'b1,
                                       ifid_flush: 1'b0, idex_flush: 1'b0, exmem_flush: 1'b0};
  localparam stage_ctrl_t CTRL_REDIRECT = '{pc_en: 1'b1, ifid_en: 1'b1, idex_en: 1'b1,
                                            ifid_flush: 1'b1, idex_flush: 1'b1, exmem_flush: 1'b1};
  // Front end frozen while EX/MEM receives bubbles until the multiply result is ready.
  localparam stage_ctrl_t CTRL_MUL_STALL = '{pc_en: 1'b0, ifid_en: 1'b0, idex_en: 1'b0,
                                             ifid_flush: 1'b0, idex_flush: 1'b0, exmem_flush: 1'b1};
  localparam stage_ctrl_t CTRL_LOAD_USE = '{pc_en: 1'b0, ifid_en: 1'b0, idex_en: 1'b1,
                                            ifid_flush: 1'b0, idex_flush: 1'b1, exmem_flush: 1'b0};

endpackage

// File: rtl/mul_seq_fsm.sv
// Multiplier sequencer: start/abort decode, iteration counter, busy flag and write-back phase.
module mul_seq_fsm
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 32,
  parameter int unsigned CNT_W      = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic i_mul_req,
  input  logic i_redir,
  output logic o_start_c,
  output logic o_abort_c,
  output logic o_stall_c,
  output logic o_idle_c,
  output logic o_busy
);

  mul_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      o_busy  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_mul_req && !i_redir) begin
            r_state <= ST_MUL_RUN;
            r_cnt   <= CNT_W'(MUL_CYCLES - 2);
            o_busy  <= 1'b1;
          end
        end
        ST_MUL_RUN: begin
          if (i_redir) begin
            r_state <= ST_IDLE;
            o_busy  <= 1'b0;
          end else if (r_cnt == '0) begin
            r_state <= ST_MUL_WB;
            o_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        // ID/EX advances on this edge, so the finished mul never re-triggers.
        ST_MUL_WB: r_state <= ST_IDLE;
        default: begin
          r_state <= ST_IDLE;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_idle_c  = (r_state == ST_IDLE);
  assign o_start_c = o_idle_c && i_mul_req && !i_redir;
  assign o_abort_c = !o_idle_c && i_redir;
  assign o_stall_c = o_start_c || ((r_state == ST_MUL_RUN) && !i_redir);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing for load-use stalls, MEM-stage redirects and the iterative multiplier.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 32,
  parameter int unsigned CNT_W      = 6,
  parameter int unsigned PERF_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        i_id_rs,
  input  logic [4:0]        i_id_rt,
  input  logic              i_id_uses_rt,
  input  logic [4:0]        i_idex_rf_wa,
  input  logic              i_idex_we_reg,
  input  logic              i_idex_dm2reg,
  input  logic              i_idex_muxmul,
  input  logic              i_exmem_jump,
  input  logic              i_exmem_jrSrc,
  output logic              o_pc_en,
  output logic              o_ifid_en,
  output logic              o_idex_en,
  output logic              o_ifid_flush,
  output logic              o_idex_flush,
  output logic              o_exmem_flush,
  output logic              o_mul_start,
  output logic              o_mul_abort,
  output logic              o_mul_busy,
  output logic [PERF_W-1:0] o_stall_cnt,
  output logic [PERF_W-1:0] o_flush_cnt
);

  logic        w_redir;
  logic        w_load_use;
  logic        w_start;
  logic        w_abort;
  logic        w_mul_stall;
  logic        w_idle;
  stage_ctrl_t w_ctrl;

  assign w_redir = i_exmem_jump || i_exmem_jrSrc;

  assign w_load_use = i_idex_dm2reg && i_idex_we_reg && (i_idex_rf_wa != REG_ZERO) &&
                      ((i_idex_rf_wa == i_id_rs) || (i_id_uses_rt && (i_idex_rf_wa == i_id_rt)));

  mul_seq_fsm #(
    .MUL_CYCLES(MUL_CYCLES),
    .CNT_W     (CNT_W)
  ) u_mul_seq (
    .clk      (clk),
    .rst      (rst),
    .i_mul_req(i_idex_muxmul),
    .i_redir  (w_redir),
    .o_start_c(w_start),
    .o_abort_c(w_abort),
    .o_stall_c(w_mul_stall),
    .o_idle_c (w_idle),
    .o_busy   (o_mul_busy)
  );

  // Priority: reset, redirect, multiply stall, load-use.
  always_comb begin
    w_ctrl = CTRL_RUN;
    if (rst)                     w_ctrl = CTRL_RUN;
    else if (w_redir)            w_ctrl = CTRL_REDIRECT;
    else if (w_mul_stall)        w_ctrl = CTRL_MUL_STALL;
    else if (w_idle && w_load_use) w_ctrl = CTRL_LOAD_USE;
  end

  assign o_pc_en       = w_ctrl.pc_en;
  assign o_ifid_en     = w_ctrl.ifid_en;
  assign o_idex_en     = w_ctrl.idex_en;
  assign o_ifid_flush  = w_ctrl.ifid_flush;
  assign o_idex_flush  = w_ctrl.idex_flush;
  assign o_exmem_flush = w_ctrl.exmem_flush;
  assign o_mul_start   = w_start && !rst;
  assign o_mul_abort   = w_abort && !rst;

  // Saturating performance counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_stall_cnt <= '0;
      o_flush_cnt <= '0;
    end else begin
      if (!w_ctrl.pc_en && (o_stall_cnt != '1)) o_stall_cnt <= o_stall_cnt + PERF_W'(1);
      if (w_redir && (o_flush_cnt != '1))       o_flush_cnt <= o_flush_cnt + PERF_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized bench for pipe_hazard_ctrl against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int unsigned MUL_CYCLES = 4;
  localparam int unsigned CNT_W      = 4;
  localparam int unsigned PERF_W     = 6;
  localparam int          SAT        = (1 << PERF_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [4:0]        id_rs = '0, id_rt = '0, idex_rf_wa = '0;
  logic              id_uses_rt = 1'b0, idex_we_reg = 1'b0, idex_dm2reg = 1'b0;
  logic              idex_muxmul = 1'b0, exmem_jump = 1'b0, exmem_jrSrc = 1'b0;
  logic              pc_en, ifid_en, idex_en, ifid_flush, idex_flush, exmem_flush;
  logic              mul_start, mul_abort, mul_busy;
  logic [PERF_W-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  // model state: stall cycles left in the multiply run, pending write-back, counters
  int  m_run_left = 0;
  bit  m_wb = 0;
  int  m_stall = 0;
  int  m_flush = 0;

  pipe_hazard_ctrl #(.MUL_CYCLES(MUL_CYCLES), .CNT_W(CNT_W), .PERF_W(PERF_W)) dut (
    .clk(clk), .rst(rst),
    .i_id_rs(id_rs), .i_id_rt(id_rt), .i_id_uses_rt(id_uses_rt),
    .i_idex_rf_wa(idex_rf_wa), .i_idex_we_reg(idex_we_reg), .i_idex_dm2reg(idex_dm2reg),
    .i_idex_muxmul(idex_muxmul), .i_exmem_jump(exmem_jump), .i_exmem_jrSrc(exmem_jrSrc),
    .o_pc_en(pc_en), .o_ifid_en(ifid_en), .o_idex_en(idex_en),
    .o_ifid_flush(ifid_flush), .o_idex_flush(idex_flush), .o_exmem_flush(exmem_flush),
    .o_mul_start(mul_start), .o_mul_abort(mul_abort), .o_mul_busy(mul_busy),
    .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One cycle: drive inputs, compare outputs against the model, advance the model, take the edge.
  task automatic step(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                      input logic [4:0] wa, input logic we, input logic dm,
                      input logic mul, input logic j, input logic jr);
    bit redir, lu, busy_e;
    logic [5:0] ctrl_e;
    logic [1:0] pulse_e;
    id_rs = rs; id_rt = rt; id_uses_rt = urt; idex_rf_wa = wa;
    idex_we_reg = we; idex_dm2reg = dm; idex_muxmul = mul;
    exmem_jump = j; exmem_jrSrc = jr;
    #3;
    redir   = j | jr;
    lu      = dm && we && (wa != 0) && ((wa == rs) || (urt && (wa == rt)));
    busy_e  = (m_run_left > 0);
    ctrl_e  = 6'b111000;
    pulse_e = 2'b00;
    if (redir) begin
      ctrl_e     = 6'b111111;
      pulse_e[0] = (m_run_left > 0) || m_wb;
      m_run_left = 0;
      m_wb       = 0;
    end else if (m_run_left > 0) begin
      ctrl_e = 6'b000001;
      m_run_left--;
      if (m_run_left == 0) m_wb = 1;
    end else if (m_wb) begin
      m_wb = 0;
    end else if (mul) begin
      ctrl_e     = 6'b000001;
      pulse_e[1] = 1'b1;
      m_run_left = MUL_CYCLES - 1;
    end else if (lu) begin
      ctrl_e = 6'b001010;
    end
    check_val("ctrl", 64'({pc_en, ifid_en, idex_en, ifid_flush, idex_flush, exmem_flush}), 64'(ctrl_e));
    check_val("start_abort", 64'({mul_start, mul_abort}), 64'(pulse_e));
    check_val("busy", 64'(mul_busy), 64'(busy_e));
    check_val("stall_cnt", 64'(stall_cnt), 64'(m_stall));
    check_val("flush_cnt", 64'(flush_cnt), 64'(m_flush));
    if (!ctrl_e[5] && m_stall < SAT) m_stall++;
    if (redir && m_flush < SAT) m_flush++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_step();
    step(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // reset values while rst is held
    idex_muxmul = 1'b1;
    #2;
    check_val("rst_ctrl", 64'({pc_en, ifid_en, idex_en, ifid_flush, idex_flush, exmem_flush}), 64'(6'b111000));
    check_val("rst_pulses", 64'({mul_start, mul_abort, mul_busy}), 64'(0));
    check_val("rst_cnts", 64'({stall_cnt, flush_cnt}), 64'(0));
    idex_muxmul = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    // load-use on rs, then no stall
    step(5'd8, 5'd9, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle_step();
    // load to $0 never stalls
    step(5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    // load-use via rt only counts when rt is read
    step(5'd1, 5'd5, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(5'd1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    // full multiply: start, stall, write-back
    for (int i = 0; i < MUL_CYCLES + 1; i++)
      step(5'd2, 5'd3, 1'b1, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    idle_step();
    // jr during the run with cnt = 1 aborts
    step(5'd2, 5'd3, 1'b1, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(5'd2, 5'd3, 1'b1, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(5'd2, 5'd3, 1'b1, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    idle_step();
    // redirect wins over load-use
    step(5'd8, 5'd9, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    // redirect in IDLE suppresses mul_start
    step(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

    // reset mid-run: busy drops asynchronously, no abort pulse
    step(5'd2, 5'd3, 1'b1, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(5'd2, 5'd3, 1'b1, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check_val("rst_mid_busy", 64'(mul_busy), 64'(0));
    check_val("rst_mid_ctrl", 64'({pc_en, exmem_flush, mul_start, mul_abort}), 64'(4'b1000));
    check_val("rst_mid_cnts", 64'({stall_cnt, flush_cnt}), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    m_run_left = 0; m_wb = 0; m_stall = 0; m_flush = 0;
    step(5'd2, 5'd3, 1'b1, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

    // randomized traffic, including counter saturation
    for (int n = 0; n < 3000; n++) begin
      step(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
           5'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0), 1'($urandom),
           1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 19) == 0),
           1'($urandom_range(0, 19) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
